dcache: RTL and testbench

- Data-side responder for the CPU memory stage's DRAM request interface (addr/wdata/rdata/write_enable/read_enable/miss).
- Direct-mapped, write-back, write-allocate cache with 16-byte lines.
- Answers hits combinationally. Holds `miss` high while it writes back a dirty victim and/or fills a line over a 128-bit valid/ready backing-memory port.
- Sits between cpu and the DRAM controller.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_if.sv | 40 ++++
 rtl/dcache_array.sv | 61 ++++++
 rtl/dcache.sv | 134 +++++++++++++
 tb/tb_dcache.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants, FSM state type and a line word-select helper
// for the data cache.
package dcache_pkg;

  localparam int LINE_BYTES = 16;
  localparam int OFFSET_W   = 4;
  localparam int LINE_W     = 128;

  typedef enum logic [1:0] {
    IDLE,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT
  } dcache_state_t;

  // Word k of a line occupies bits [32k+31:32k].
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [1:0]        w);
    return line[32*w +: 32];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU request side and backing-memory side of the data cache.
//   CPU side : addr, wdata, write_enable, read_enable -> rdata, miss
//   Mem side : mem_valid/mem_ready request handshake with mem_we, mem_addr,
//              mem_wdata; mem_rvalid/mem_rdata fill response.
// slave  = the cache's view, master = the CPU/memory environment's view.
interface dcache_if #(
  parameter int ADDR_W = 32
);
  import dcache_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              write_enable;
  logic              read_enable;
  logic [31:0]       rdata;
  logic              miss;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [LINE_W-1:0] mem_rdata;

  modport slave (
    input  addr, wdata, write_enable, read_enable,
    input  mem_ready, mem_rvalid, mem_rdata,
    output rdata, miss,
    output mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output addr, wdata, write_enable, read_enable,
    output mem_ready, mem_rvalid, mem_rdata,
    input  rdata, miss,
    input  mem_valid, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_array.sv
// dcache_array: tag/data/valid/dirty storage for a direct-mapped cache.
//   idx               : combinational read index, also the word-write index
//   rd_valid/rd_dirty/rd_tag/rd_line : contents of line idx
//   wr_en/wr_word/wr_data : store one 32-bit word into line idx, set dirty
//   fill_en/fill_idx/fill_tag/fill_line : install a full line, valid=1 dirty=0
// Only valid and dirty are cleared by reset; tags and data are not.
module dcache_array #(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 20,
  parameter int LINE_W  = 128
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [INDEX_W-1:0] idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               wr_en,
  input  logic [1:0]         wr_word,
  input  logic [31:0]        wr_data,
  input  logic               fill_en,
  input  logic [INDEX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [LINE_W-1:0]  fill_line
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
      dirty_q[fill_idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_line;
    end else if (wr_en) begin
      data_q[idx][32*wr_word +: 32] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache, 16-byte lines.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : dcache_if.slave - CPU load/store request with combinational
//               hit response and miss stall; 128-bit line port to memory.
// Hits complete in the request cycle. A miss optionally writes back the dirty
// victim (WB_REQ), then requests the line (FILL_REQ), waits for the response
// (FILL_WAIT) and returns to IDLE where the held request then hits.
module dcache
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int ADDR_W  = 32
) (
  input  logic     clk,
  input  logic     rstn,
  dcache_if.slave  bus
);

  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         word;

  assign idx  = bus.addr[OFFSET_W +: INDEX_W];
  assign tag  = bus.addr[ADDR_W-1 -: TAG_W];
  assign word = bus.addr[3:2];

  logic               line_valid;
  logic               line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [LINE_W-1:0]  line_data;

  dcache_state_t      state;
  logic [INDEX_W-1:0] lat_idx;
  logic [TAG_W-1:0]   lat_tag;
  logic               mem_valid_q;
  logic               mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [LINE_W-1:0]  mem_wdata_q;

  logic req;
  logic hit;
  logic wr_en;
  logic fill_en;

  assign req     = bus.read_enable | bus.write_enable;
  assign hit     = line_valid && (line_tag == tag);
  assign bus.miss = req && !((state == IDLE) && hit);
  // A store wins over a load when both enables are high.
  assign wr_en   = (state == IDLE) && hit && bus.write_enable;
  assign fill_en = (state == FILL_WAIT) && bus.mem_rvalid;

  assign bus.rdata     = rstn ? line_word(line_data, word) : '0;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  dcache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .LINE_W  (LINE_W)
  ) u_array (
    .clk       (clk),
    .rstn      (rstn),
    .idx       (idx),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_line   (line_data),
    .wr_en     (wr_en),
    .wr_word   (word),
    .wr_data   (bus.wdata),
    .fill_en   (fill_en),
    .fill_idx  (lat_idx),
    .fill_tag  (lat_tag),
    .fill_line (bus.mem_rdata)
  );

  // The missing index/tag are latched so a withdrawn or changed request
  // cannot redirect an in-flight fill.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      lat_idx     <= '0;
      lat_tag     <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            lat_idx     <= idx;
            lat_tag     <= tag;
            mem_valid_q <= 1'b1;
            if (line_valid && line_dirty) begin
              state       <= WB_REQ;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {line_tag, idx, {OFFSET_W{1'b0}}};
              mem_wdata_q <= line_data;
            end else begin
              state      <= FILL_REQ;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag, idx, {OFFSET_W{1'b0}}};
            end
          end
        end
        WB_REQ: begin
          if (bus.mem_ready) begin
            state      <= FILL_REQ;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {lat_tag, lat_idx, {OFFSET_W{1'b0}}};
          end
        end
        FILL_REQ: begin
          if (bus.mem_ready) begin
            state       <= FILL_WAIT;
            mem_valid_q <= 1'b0;
          end
        end
        FILL_WAIT: begin
          if (bus.mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
module tb_dcache;
  import dcache_pkg::*;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;  // victim data for write-back, response data for fill
  } mem_req_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dcache_if #(.ADDR_W(32)) bus ();

  dcache #(.INDEX_W(8), .ADDR_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  mem_req_t    exp_q[$];
  logic [31:0] rd_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.read_enable  = re;
    bus.write_enable = we;
    bus.addr         = a;
    bus.wdata        = d;
    #1;
  endtask

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [127:0] d);
    mem_req_t r;
    r.we = we; r.addr = a; r.data = d;
    exp_q.push_back(r);
  endtask

  // Wait (bounded) for a request, compare it with the scoreboard head, hold
  // mem_ready low for 'delay' cycles checking stability, accept it and, for a
  // fill, return the response in the following cycle.
  task automatic serve(input int unsigned delay);
    mem_req_t    e;
    int unsigned n = 0;
    while (!bus.mem_valid && n < 20) begin
      tick();
      n++;
    end
    check("mem_valid_seen", bus.mem_valid, 1'b1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_underflow observed=request expected=none");
      return;
    end
    e = exp_q.pop_front();
    check("mem_we", bus.mem_we, e.we);
    check("mem_addr", bus.mem_addr, e.addr);
    if (e.we) check("mem_wdata", bus.mem_wdata, e.data);
    for (int unsigned i = 0; i < delay; i++) begin
      tick();
      check("hold_valid", bus.mem_valid, 1'b1);
      check("hold_we", bus.mem_we, e.we);
      check("hold_addr", bus.mem_addr, e.addr);
      if (e.we) check("hold_wdata", bus.mem_wdata, e.data);
      check("hold_miss", bus.miss, 1'b1);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    if (!e.we) begin
      check("fill_wait_valid", bus.mem_valid, 1'b0);
      check("fill_wait_miss", bus.miss, 1'b1);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = e.data;
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end
  endtask

  task automatic finish_read();
    logic [31:0] e;
    int unsigned n = 0;
    while (bus.miss && n < 20) begin
      tick();
      n++;
    end
    check("read_done_miss", bus.miss, 1'b0);
    if (rd_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL rd_underflow observed=read expected=none");
      return;
    end
    e = rd_q.pop_front();
    check("rdata", bus.rdata, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.read_enable = 1'b0; bus.write_enable = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    check("rst_mem_valid", bus.mem_valid, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 128'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_miss", bus.miss, 1'b0);
    rstn = 1'b1;
    tick();

    // 1: clean miss and fill
    rd_q.push_back(32'h2222_2222);
    push_mem(1'b0, 32'h0000_1000, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    cpu_drive(1'b1, 1'b0, 32'h0000_1004, 32'h0);
    check("t1_miss", bus.miss, 1'b1);
    serve(0);
    finish_read();

    // 2: read hit, no traffic
    rd_q.push_back(32'h3333_3333);
    cpu_drive(1'b1, 1'b0, 32'h0000_1008, 32'h0);
    check("t2_miss", bus.miss, 1'b0);
    finish_read();
    check("t2_no_mem", bus.mem_valid, 1'b0);
    tick();
    check("t2_no_mem_next", bus.mem_valid, 1'b0);

    // 3: write hit then readback
    cpu_drive(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    check("t3_wr_miss", bus.miss, 1'b0);
    tick();
    check("t3_no_mem", bus.mem_valid, 1'b0);
    rd_q.push_back(32'hDEAD_BEEF);
    cpu_drive(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    finish_read();

    // 4: dirty conflict miss: write-back then fill
    push_mem(1'b1, 32'h0000_1000, 128'h4444_4444_3333_3333_2222_2222_DEAD_BEEF);
    push_mem(1'b0, 32'h0000_2000, 128'h8888_8888_7777_7777_6666_6666_5555_5555);
    rd_q.push_back(32'h5555_5555);
    cpu_drive(1'b1, 1'b0, 32'h0000_2000, 32'h0);
    check("t4_miss", bus.miss, 1'b1);
    serve(0);
    serve(0);
    finish_read();

    // 5: dirty the new line, then write-back held off by mem_ready for 5 cycles
    cpu_drive(1'b0, 1'b1, 32'h0000_2004, 32'hCAFE_F00D);
    check("t5_wr_miss", bus.miss, 1'b0);
    tick();
    push_mem(1'b1, 32'h0000_2000, 128'h8888_8888_7777_7777_CAFE_F00D_5555_5555);
    push_mem(1'b0, 32'h0000_3000, 128'h0000_000D_0000_000C_0000_000B_0000_000A);
    rd_q.push_back(32'h0000_000D);
    cpu_drive(1'b1, 1'b0, 32'h0000_300C, 32'h0);
    serve(5);
    serve(0);
    finish_read();

    // write miss to a clean index: allocate, then merge the store
    push_mem(1'b0, 32'h0000_0400, 128'h0404_0404_0303_0303_0202_0202_0101_0101);
    cpu_drive(1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678);
    check("wm_miss", bus.miss, 1'b1);
    serve(0);
    check("wm_merge_miss", bus.miss, 1'b0);
    tick();
    rd_q.push_back(32'h1234_5678);
    cpu_drive(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    finish_read();
    rd_q.push_back(32'h0202_0202);
    cpu_drive(1'b1, 1'b0, 32'h0000_0404, 32'h0);
    finish_read();

    // 6: reset during FILL_WAIT, late response dropped, miss repeats
    push_mem(1'b0, 32'h0000_1000, 128'h0);
    cpu_drive(1'b1, 1'b0, 32'h0000_1004, 32'h0);
    check("t6_miss", bus.miss, 1'b1);
    tick();
    begin
      mem_req_t e;
      check("t6_req_valid", bus.mem_valid, 1'b1);
      e = exp_q.pop_front();
      check("t6_req_addr", bus.mem_addr, e.addr);
      check("t6_req_we", bus.mem_we, e.we);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    rstn = 1'b0;
    #1;
    check("t6_rst_valid", bus.mem_valid, 1'b0);
    check("t6_rst_addr", bus.mem_addr, 32'h0);
    check("t6_rst_rdata", bus.rdata, 32'h0);
    tick();
    rstn = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    #1;
    check("t6_post_rst_miss", bus.miss, 1'b1);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    push_mem(1'b0, 32'h0000_1000, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    rd_q.push_back(32'h2222_2222);
    serve(0);
    finish_read();
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("end_idle_valid", bus.mem_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
